alu_ctrl_seq: RTL

Registered, handshaked successor to the combinational ALU control decoder. Accepts an {ALU_OPcode, OPcode} pair from the decode stage and drives ALU_CTRL to the execute stage with valid/ready flow control. Generalised in field widths and extended with multi-cycle operation sequencing: iterative ALU operations are held for MC_CYCLES beats with first/last markers. Illegal encodings are flagged instead of silently mapped.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_ctrl_seq_if.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 53 +++++
 rtl/alu_ctrl_seq.sv | 96 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared sizes, ALU_OPcode class and ALU_CTRL code constants,
// the sequencer FSM state type and a beat-counter width helper.
package alu_pkg;

    localparam int OP_CODE_SIZE_D  = 4;
    localparam int ALU_OP_SIZE_D   = 2;
    localparam int ALU_CTRL_SIZE_D = 3;
    localparam int MC_BASE_D       = 6;
    localparam int MC_CYCLES_D     = 4;

    // Operation classes (ALU_OPcode)
    localparam int CLS_RTYPE  = 0;
    localparam int CLS_BRANCH = 1;
    localparam int CLS_MEM    = 2;
    localparam int CLS_RSVD   = 3;

    // ALU_CTRL codes
    localparam int CTRL_MEM    = 0;
    localparam int CTRL_BRANCH = 1;
    localparam int CTRL_ILL    = 0;

    // R-type opcodes RTYPE_LO..RTYPE_HI map to codes 0..7
    localparam int RTYPE_LO = 2;
    localparam int RTYPE_HI = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_MULTI
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-side and execute-side handshakes of the sequencer.
// master = decode/execute environment, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
    parameter int OP_CODE_SIZE  = alu_pkg::OP_CODE_SIZE_D,
    parameter int ALU_OP_SIZE   = alu_pkg::ALU_OP_SIZE_D,
    parameter int ALU_CTRL_SIZE = alu_pkg::ALU_CTRL_SIZE_D
);

    logic                     in_valid;
    logic                     in_ready;
    logic [OP_CODE_SIZE-1:0]  OPcode;
    logic [ALU_OP_SIZE-1:0]   ALU_OPcode;
    logic                     out_valid;
    logic                     out_ready;
    logic [ALU_CTRL_SIZE-1:0] ALU_CTRL;
    logic                     out_first;
    logic                     out_last;
    logic                     illegal;

    modport master (
        output in_valid, OPcode, ALU_OPcode, out_ready,
        input  in_ready, out_valid, ALU_CTRL, out_first, out_last, illegal
    );

    modport slave (
        input  in_valid, OPcode, ALU_OPcode, out_ready,
        output in_ready, out_valid, ALU_CTRL, out_first, out_last, illegal
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {ALU_OPcode, OPcode} -> ALU_CTRL table.
// Ports: alu_op_i, opcode_i in; code_o, illegal_o, is_multi_o out.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int OP_CODE_SIZE  = OP_CODE_SIZE_D,
    parameter int ALU_OP_SIZE   = ALU_OP_SIZE_D,
    parameter int ALU_CTRL_SIZE = ALU_CTRL_SIZE_D,
    parameter int MC_BASE       = MC_BASE_D,
    parameter int MC_CYCLES     = MC_CYCLES_D
) (
    input  logic [ALU_OP_SIZE-1:0]   alu_op_i,
    input  logic [OP_CODE_SIZE-1:0]  opcode_i,
    output logic [ALU_CTRL_SIZE-1:0] code_o,
    output logic                     illegal_o,
    output logic                     is_multi_o
);

    logic [OP_CODE_SIZE-1:0] rel;
    logic                    in_rng;

    assign rel    = opcode_i - OP_CODE_SIZE'(RTYPE_LO);
    assign in_rng = (opcode_i >= OP_CODE_SIZE'(RTYPE_LO)) &&
                    (opcode_i <= OP_CODE_SIZE'(RTYPE_HI));

    always_comb begin
        code_o    = ALU_CTRL_SIZE'(CTRL_ILL);
        illegal_o = 1'b0;
        case (alu_op_i)
            ALU_OP_SIZE'(CLS_MEM): begin
                code_o = ALU_CTRL_SIZE'(CTRL_MEM);
            end
            ALU_OP_SIZE'(CLS_BRANCH): begin
                code_o = ALU_CTRL_SIZE'(CTRL_BRANCH);
            end
            ALU_OP_SIZE'(CLS_RTYPE): begin
                if (in_rng) begin
                    code_o = ALU_CTRL_SIZE'(rel);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // Illegal ops never iterate, even when their code reaches MC_BASE
    assign is_multi_o = (MC_CYCLES > 1) && !illegal_o &&
                        (int'(code_o) >= MC_BASE);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control with multi-cycle beats.
// Ports: clk, rst (async, active-high); bus (slave) carries both handshakes.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int OP_CODE_SIZE  = OP_CODE_SIZE_D,
    parameter int ALU_OP_SIZE   = ALU_OP_SIZE_D,
    parameter int ALU_CTRL_SIZE = ALU_CTRL_SIZE_D,
    parameter int MC_BASE       = MC_BASE_D,
    parameter int MC_CYCLES     = MC_CYCLES_D
) (
    input  logic          clk,
    input  logic          rst,
    alu_ctrl_seq_if.slave bus
);

    localparam int            CW       = cnt_width(MC_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [ALU_CTRL_SIZE-1:0] code_q, code_d;
    logic                     ill_q, ill_d;

    logic [ALU_CTRL_SIZE-1:0] dec_code;
    logic                     dec_ill;
    logic                     dec_multi;

    logic valid, first, last, ready, accept;

    alu_ctrl_decode #(
        .OP_CODE_SIZE  (OP_CODE_SIZE),
        .ALU_OP_SIZE   (ALU_OP_SIZE),
        .ALU_CTRL_SIZE (ALU_CTRL_SIZE),
        .MC_BASE       (MC_BASE),
        .MC_CYCLES     (MC_CYCLES)
    ) u_dec (
        .alu_op_i   (bus.ALU_OPcode),
        .opcode_i   (bus.OPcode),
        .code_o     (dec_code),
        .illegal_o  (dec_ill),
        .is_multi_o (dec_multi)
    );

    assign valid  = (state_q != ST_IDLE);
    assign first  = valid && (cnt_q == '0);
    assign last   = (state_q == ST_SINGLE) ||
                    ((state_q == ST_MULTI) && (cnt_q == CNT_LAST));
    // A new op may enter on the same edge the final beat leaves
    assign ready  = !valid || (bus.out_ready && last);
    assign accept = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ill_d   = ill_q;
        if (accept) begin
            state_d = dec_multi ? ST_MULTI : ST_SINGLE;
            cnt_d   = '0;
            code_d  = dec_code;
            ill_d   = dec_ill;
        end else if (valid && bus.out_ready) begin
            if (last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                code_d  = '0;
                ill_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.ALU_CTRL  = code_q;
    assign bus.out_first = first;
    assign bus.out_last  = last;
    assign bus.illegal   = ill_q;

endmodule
